fetch_decode_buffer: RTL and testbench

FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_decode_buffer.sv | 92 +++++++++
 tb/tb_fetch_decode_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch-to-decode instruction buffer.
// One buffered entry holds the instruction word, its PC and PC+4.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } entry_t;

endpackage

// File: rtl/fetch_decode_buffer.sv
// Two-entry skid FIFO between instruction fetch and decode.
// Head outputs show a NOP with zero PCs whenever the buffer is empty.
module fetch_decode_buffer
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATAOUT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATAOUT_WIDTH-1:0] instr_in,
    input  logic [ADDRESS_WIDTH-1:0] pc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATAOUT_WIDTH-1:0] instr_out,
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_out,
    input  logic                     flush,
    output logic [1:0]               count
);

    entry_t     mem [2];
    entry_t     head;
    entry_t     wr_entry;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count_q;
    logic       push;
    logic       pop;

    logic [ADDRESS_WIDTH-1:0] pc_inc;

    // Ready/valid decode only from the occupancy register.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign count     = count_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    assign pc_inc = pc_in + ADDRESS_WIDTH'(4);

    always_comb begin
        wr_entry          = '0;
        wr_entry.instr    = XLEN'(instr_in);
        wr_entry.pc       = XLEN'(pc_in);
        wr_entry.pc_plus4 = XLEN'(pc_inc);
    end

    assign head = mem[rd_ptr];

    always_comb begin
        instr_out    = DATAOUT_WIDTH'(NOP);
        pc_out       = '0;
        pc_plus4_out = '0;
        if (out_valid) begin
            instr_out    = DATAOUT_WIDTH'(head.instr);
            pc_out       = ADDRESS_WIDTH'(head.pc);
            pc_plus4_out = ADDRESS_WIDTH'(head.pc_plus4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for the fetch-to-decode buffer.
// A queue mirrors buffer contents; the head is compared on every cycle.
module tb_fetch_decode_buffer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        flush;
    logic [1:0]  count;

    int n_chk = 0;
    int n_err = 0;

    entry_t q[$];

    fetch_decode_buffer #(
        .ADDRESS_WIDTH(32),
        .DATAOUT_WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .pc_plus4_out(pc_plus4_out),
        .flush       (flush),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic rdy,
                         input logic fl);
        in_valid  = v;
        pc_in     = pc;
        instr_in  = ins;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic chk_state(input string tag);
        int sz;
        sz = q.size();
        chk({tag, "_count"}, 64'(count), 64'(sz));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(sz < 2));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(sz > 0));
        if (sz > 0) begin
            chk({tag, "_instr"}, 64'(instr_out), 64'(q[0].instr));
            chk({tag, "_pc"}, 64'(pc_out), 64'(q[0].pc));
            chk({tag, "_pc4"}, 64'(pc_plus4_out), 64'(q[0].pc_plus4));
        end else begin
            chk({tag, "_instr"}, 64'(instr_out), 64'(32'h13));
            chk({tag, "_pc"}, 64'(pc_out), 64'(0));
            chk({tag, "_pc4"}, 64'(pc_plus4_out), 64'(0));
        end
    endtask

    // Check current outputs, advance the model, then take one clock edge.
    task automatic cyc(input string tag);
        entry_t e;
        bit     push_ok;
        chk_state(tag);
        push_ok = in_valid && (q.size() < 2) && !flush;
        if (flush) begin
            q.delete();
        end else begin
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (push_ok) begin
                e.instr    = instr_in;
                e.pc       = pc_in;
                e.pc_plus4 = pc_in + 32'd4;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        chk_state("rst");
        @(negedge clk);
        rst = 1'b1;

        // Single push, decode stalled.
        drive(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
        cyc("s1_push");
        chk("s1_count", 64'(count), 64'(1));
        chk("s1_pc4", 64'(pc_plus4_out), 64'(32'h4));

        // Fill, then a third request is ignored.
        drive(1'b1, 32'h4, 32'h0010_0113, 1'b0, 1'b0);
        cyc("s2_push");
        chk("s2_in_ready", 64'(in_ready), 64'(0));
        drive(1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0);
        cyc("s2_full");
        chk("s2_head_pc", 64'(pc_out), 64'(32'h0));
        chk("s2_count", 64'(count), 64'(2));

        // Drain, then pop from empty.
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc("drain0");
        cyc("drain1");
        cyc("pop_empty");
        chk("empty_count", 64'(count), 64'(0));

        // Simultaneous push and pop at count 1.
        drive(1'b1, 32'h8, 32'h0020_0193, 1'b0, 1'b0);
        cyc("s3_fill");
        drive(1'b1, 32'hC, 32'h0030_0213, 1'b1, 1'b0);
        cyc("s3_pp");
        chk("s3_count", 64'(count), 64'(1));
        chk("s3_pc", 64'(pc_out), 64'(32'hC));
        chk("s3_instr", 64'(instr_out), 64'(32'h0030_0213));

        // Flush overrides push and pop.
        drive(1'b1, 32'h10, 32'h0040_0293, 1'b0, 1'b0);
        cyc("s4_fill");
        drive(1'b1, 32'h14, 32'h0050_0313, 1'b1, 1'b1);
        cyc("s4_flush");
        chk("s4_count", 64'(count), 64'(0));
        chk("s4_out_valid", 64'(out_valid), 64'(0));
        chk("s4_nop", 64'(instr_out), 64'(32'h13));

        // PC+4 wraps.
        drive(1'b1, 32'hFFFF_FFFC, 32'h0060_0393, 1'b0, 1'b0);
        cyc("s5_push");
        chk("s5_pc4", 64'(pc_plus4_out), 64'(32'h0));

        // Asynchronous reset between edges at count 2.
        drive(1'b1, 32'h20, 32'h0070_0413, 1'b0, 1'b0);
        cyc("s6_fill");
        chk("s6_full", 64'(count), 64'(2));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        chk_state("s6_async");
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h100, 32'h0080_0493, 1'b0, 1'b0);
        cyc("s6_first");
        chk("s6_count", 64'(count), 64'(1));
        chk("s6_pc", 64'(pc_out), 64'(32'h100));

        // Random traffic with occasional flushes.
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                  $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
            cyc("rand");
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_state("final");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
